// File: rtl/led_blink_sequencer_pkg.sv
// Shared definitions for the status LED blink sequencer and its helpers:
// FSM state encoding, LED intensity levels and a small sizing helper.
package led_blink_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    localparam logic [3:0] LED_FULL = 4'hF;
    localparam logic [3:0] LED_DARK = 4'h0;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
// Shared with the downstream PWM/breathing LED stage.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic sysClock,
    input  logic nReset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) cnt_d = '0;
    end

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_sequencer.sv
// Blinks a 4-bit status code as N full-intensity pulses followed by a dark gap,
// overriding the downstream LED stage while a sequence runs.
module led_blink_sequencer
    import led_blink_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 2500000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned GAP_TICKS = 10
) (
    input  logic       sysClock,
    input  logic       nReset,
    input  logic [3:0] codeIn,
    input  logic       codeValid,
    output logic       codeReady,
    input  logic       codeAbort,
    output logic [3:0] ledLevel,
    output logic       ledOverride,
    output logic       busy
);

    localparam int unsigned TW = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

    seq_state_e    state_q;
    logic [TW-1:0] tcnt_q;
    logic [3:0]    remaining_q;
    logic          ready_q;
    logic [3:0]    level_q;
    logic          override_q;
    logic          busy_q;

    logic tick;
    logic start;
    logic phase_last;

    // Abort in IDLE masks acceptance; ready_q is only high in IDLE.
    assign start = codeValid && ready_q && !codeAbort && (codeIn != 4'd0);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .sysClock(sysClock),
        .nReset  (nReset),
        .clr     (start),
        .tick    (tick)
    );

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            ST_ON:   phase_last = (tcnt_q == TW'(ON_TICKS - 1));
            ST_OFF:  phase_last = (tcnt_q == TW'(OFF_TICKS - 1));
            ST_GAP:  phase_last = (tcnt_q == TW'(GAP_TICKS - 1));
            default: phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            remaining_q <= '0;
            ready_q     <= 1'b1;
            level_q     <= LED_DARK;
            override_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (codeAbort && (state_q != ST_IDLE)) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            remaining_q <= '0;
            ready_q     <= 1'b1;
            level_q     <= LED_DARK;
            override_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_ON;
                        tcnt_q      <= '0;
                        remaining_q <= codeIn;
                        ready_q     <= 1'b0;
                        level_q     <= LED_FULL;
                        override_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (phase_last) begin
                            tcnt_q      <= '0;
                            remaining_q <= remaining_q - 4'd1;
                            level_q     <= LED_DARK;
                            state_q     <= (remaining_q == 4'd1) ? ST_GAP : ST_OFF;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (phase_last) begin
                            tcnt_q  <= '0;
                            level_q <= LED_FULL;
                            state_q <= ST_ON;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (phase_last) begin
                            tcnt_q     <= '0;
                            state_q    <= ST_IDLE;
                            ready_q    <= 1'b1;
                            override_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign codeReady   = ready_q;
    assign ledLevel    = level_q;
    assign ledOverride = override_q;
    assign busy        = busy_q;

endmodule
